// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter
//
// Shares a single-wire serial bus among N nodes. One requester at a time is
// granted (round-robin by default). The winner's sender index, receiver
// address, payload and CRC are snapshotted and shifted out MSB first on
// bus_show, preceded by a start bit.
//
// Frame (FRAME_LEN = 1 + ADDR_W + ADDR_W + DATA_W + CRC_W = 77 bits):
//   start(1) | sender(ADDR_W) | receiver(ADDR_W) | payload(DATA_W) | crc(CRC_W)
//
// Ports:
//   clock     in   system clock, rising edge
//   reset     in   synchronous, active-high reset
//   req       in   [N]         request vector, bit i = node i
//   data_in   in   [N*DATA_W]  node i payload at [i*DATA_W +: DATA_W]
//   addr_in   in   [N*ADDR_W]  node i receiver address at [i*ADDR_W +: ADDR_W]
//   crc_in    in   [N*CRC_W]   node i CRC at [i*CRC_W +: CRC_W]
//   grant     out  [N]         one-hot frame owner, held for the whole frame
//   busy      out              high while a frame is on the bus
//   done      out  [N]         one-hot pulse coincident with the last frame bit
//   bus_show  out              serial bus line, idles low
//
// Build option:
//   ARB_FIXED_PRIO_EN  defined   -> fixed priority, lowest set req index wins
//                      undefined -> round-robin starting after the last grant
// -----------------------------------------------------------------------------
module bus_arbiter #(
  parameter int N      = 16,
  parameter int DATA_W = 64,
  parameter int CRC_W  = 4,
  parameter int ADDR_W = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [N-1:0]          req,
  input  logic [N*DATA_W-1:0]   data_in,
  input  logic [N*ADDR_W-1:0]   addr_in,
  input  logic [N*CRC_W-1:0]    crc_in,
  output logic [N-1:0]          grant,
  output logic                  busy,
  output logic [N-1:0]          done,
  output logic                  bus_show
);

  localparam int FRAME_LEN = 1 + ADDR_W + ADDR_W + DATA_W + CRC_W;
  // The start bit is driven directly at the grant edge, so only the rest of
  // the frame lives in the shift register.
  localparam int SHIFT_W   = FRAME_LEN - 1;
  localparam int CNT_W     = $clog2(FRAME_LEN);

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  state_t              state;
  logic [SHIFT_W-1:0]  shift_reg;
  logic [CNT_W-1:0]    bit_cnt;

  logic [ADDR_W-1:0]   win_idx;
  logic                win_found;
  logic [ADDR_W-1:0]   cand;
  logic [N-1:0]        win_onehot;
  logic [SHIFT_W-1:0]  frame_body;

`ifndef ARB_FIXED_PRIO_EN
  logic [ADDR_W-1:0]   last_grant;
`endif

  // ---------------------------------------------------------------------------
  // Winner selection. Round-robin scans upward from last_grant+1; the ADDR_W
  // wide addition wraps N-1 back to 0 on its own because N == 2**ADDR_W.
  // ---------------------------------------------------------------------------
  // NOTE: every variable assigned here gets a default first, otherwise a
  // path that skips the assignment would infer a latch.
  always_comb begin
    win_idx   = '0;
    win_found = 1'b0;
    cand      = '0;
    for (int i = 0; i < N; i++) begin
`ifdef ARB_FIXED_PRIO_EN
      cand = ADDR_W'(i);
`else
      cand = last_grant + ADDR_W'(i + 1);
`endif
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    win_onehot          = '0;
    win_onehot[win_idx] = 1'b1;
  end

  assign frame_body = {win_idx,
                       addr_in[win_idx*ADDR_W +: ADDR_W],
                       data_in[win_idx*DATA_W +: DATA_W],
                       crc_in [win_idx*CRC_W  +: CRC_W]};

  // ---------------------------------------------------------------------------
  // Frame FSM. bit_cnt holds k after the edge that put frame bit k on the bus.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      // NOTE: shift_reg is pure datapath and is deliberately left out of
      // reset; it is always reloaded before any of its bits reach bus_show.
      state      <= IDLE;
      grant      <= '0;
      busy       <= 1'b0;
      done       <= '0;
      bus_show   <= 1'b0;
      bit_cnt    <= '0;
`ifndef ARB_FIXED_PRIO_EN
      last_grant <= ADDR_W'(N - 1);
`endif
    end else begin
      case (state)
        IDLE: begin
          bus_show <= 1'b0;
          busy     <= 1'b0;
          grant    <= '0;
          done     <= '0;
          if (win_found) begin
            shift_reg  <= frame_body;
            grant      <= win_onehot;
`ifndef ARB_FIXED_PRIO_EN
            last_grant <= win_idx;
`endif
            busy       <= 1'b1;
            bus_show   <= 1'b1;     // start bit
            bit_cnt    <= '0;
            state      <= SEND;
          end
        end

        SEND: begin
          if (bit_cnt == CNT_W'(FRAME_LEN - 1)) begin
            // Last bit has had its cycle: release the bus for one low cycle.
            bus_show <= 1'b0;
            grant    <= '0;
            busy     <= 1'b0;
            done     <= '0;
            state    <= IDLE;
          end else begin
            bus_show  <= shift_reg[SHIFT_W-1];
            shift_reg <= {shift_reg[SHIFT_W-2:0], 1'b0};
            bit_cnt   <= bit_cnt + 1'b1;
            // The edge that drives the final bit also raises done.
            done      <= (bit_cnt == CNT_W'(FRAME_LEN - 2)) ? grant : '0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
